pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register for the ARM pipeline stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces hand-written per-stage registers with a valid/ready handshake and synchronous flush. It also provides an optional two-entry skid buffer, so stalls propagate backward with no combinational path from `out_ready` to `in_ready`. Payload is split into a control field, zeroed on bubbles and flushes, and a data field.

## Interface
- `CTRL_W`, default 8: width of control field (wb_en, mem_r_en, mem_w_en, status_w_en, branch_taken, …); forced to 0 whenever the stage holds a bubble.
- `DATA_W`, default 128: width of data field (pc, val_rn, val_rm, imm24, dest, …).
- `SKID`, default 1: 1 = two-entry skid buffer, `in_ready` depends on state only; 0 = single register, `in_ready` combinational.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous kill of all held and incoming entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage accepts an entry this cycle.
- `in_ctrl` in CTRL_W: incoming control field.
- `in_data` in DATA_W: incoming data field.
- `out_valid` out 1: entry presented downstream.
- `out_ready` in 1: downstream accepts; deassert to freeze.
- `out_ctrl` out CTRL_W: held control field; 0 when `out_valid`=0.
- `out_data` out DATA_W: held data field.
- `occupancy` out 2: number of held entries (0..2).

## Operation
- Storage: main register M drives `out_*`. Skid register S exists only if SKID=1.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (M full), TWO (M and S full; SKID=1 only).
- EMPTY: in_fire -> M<=in, ONE.
- ONE, in_fire & out_fire: M<=in, stay ONE.
- ONE, in_fire & ~out_fire: S<=in, TWO. With SKID=0 this cannot occur.
- ONE, out_fire only: EMPTY. M ctrl cleared to 0.
- TWO, out_fire: M<=S, S cleared, ONE. No in_fire possible because `in_ready`=0.
- `in_ready`: SKID=1 -> (state != TWO), a function of the state register only. SKID=0 -> ~out_valid | out_ready.
- `out_valid` = (state != EMPTY). `out_ctrl` = M.ctrl & {CTRL_W{out_valid}}.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush has priority over all transfers. It moves state to EMPTY and zeroes M and S (ctrl and data). Any in_fire in the flush cycle is discarded. An out_fire in the flush cycle still counts as consumed downstream.
- Reset (async) puts state in EMPTY with all registers zero. Reset asserted mid-transfer aborts it with no partial update.

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 (SKID=1) or 1 via ~out_valid (SKID=0).
- Latency: in_fire at edge N puts the entry on `out_*` after edge N+1, i.e. 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1, for both SKID values.
- SKID=1: after out_ready falls, stage absorbs at most one further entry. `in_ready` falls the cycle after the entry enters S.
- `in_ready` rises the cycle after TWO->ONE.
- Flush at edge N: after edge N, out_valid=0, occupancy=0, in_ready=1.

## Test plan
- Reset then stream 8 entries (ctrl=i, data=0x100+i), out_ready=1: out_valid from cycle 2, outputs 0..7 in order, in_ready stays 1, occupancy ≤1.
- SKID=1, out_ready low for 3 cycles mid-stream: occupancy 1->2, in_ready=0 during stall, no loss or duplicate. After release, S drains to M next cycle and in_ready returns 1.
- SKID=0, same stall: in_ready tracks out_ready combinationally, occupancy never exceeds 1, order preserved.
- Flush while occupancy=2 with in_valid=1: next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0. The flushed input never appears at the output.
- Bubble check: in_valid=0 for 1 cycle between entries with nonzero ctrl: out_ctrl=0 during the bubble cycle.
- Assert rst asynchronously mid-stream, between clock edges: outputs zero immediately. The first entry after release appears with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with optional two-entry skid buffer
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t            state, state_nx;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_nx, s_ctrl, s_ctrl_nx;
    logic [DATA_W-1:0] m_data, m_data_nx, s_data, s_data_nx;
    logic              in_fire, out_fire;
    assign out_valid = state != EMPTY;
    // with the skid buffer, in_ready is registered-only so stalls never ripple combinationally
    assign in_ready  = (SKID != 0) ? (state != TWO) : (~out_valid | out_ready);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = m_ctrl & {CTRL_W{out_valid}};
    assign out_data  = m_data;
    assign occupancy = state;
    always_comb begin
        state_nx  = state;
        m_ctrl_nx = m_ctrl;
        m_data_nx = m_data;
        s_ctrl_nx = s_ctrl;
        s_data_nx = s_data;
        if (flush) begin
            state_nx  = EMPTY;
            m_ctrl_nx = '0;
            m_data_nx = '0;
            s_ctrl_nx = '0;
            s_data_nx = '0;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx  = ONE;
                    m_ctrl_nx = in_ctrl;
                    m_data_nx = in_data;
                end
                ONE: if (in_fire && out_fire) begin
                    m_ctrl_nx = in_ctrl;
                    m_data_nx = in_data;
                end else if (in_fire) begin
                    state_nx  = TWO;
                    s_ctrl_nx = in_ctrl;
                    s_data_nx = in_data;
                end else if (out_fire) begin
                    state_nx  = EMPTY;
                    m_ctrl_nx = '0;
                end
                TWO: if (out_fire) begin
                    state_nx  = ONE;
                    m_ctrl_nx = s_ctrl;
                    m_data_nx = s_data;
                    s_ctrl_nx = '0;
                    s_data_nx = '0;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else begin
            state  <= state_nx;
            m_ctrl <= m_ctrl_nx;
            m_data <= m_data_nx;
            s_ctrl <= s_ctrl_nx;
            s_data <= s_data_nx;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg with SKID=1 and SKID=0 instances
module tb_pipe_stage_reg;
    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic         in_ready1, out_valid1, in_ready0, out_valid0;
    logic [7:0]   out_ctrl1, out_ctrl0;
    logic [127:0] out_data1, out_data0;
    logic [1:0]   occ1, occ0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
    );
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [127:0] d, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic exp1(input string t, input logic v, input logic [7:0] c, input logic [127:0] d,
                        input logic [1:0] o, input logic r);
        check({t, ".valid1"}, out_valid1, v);
        check({t, ".ctrl1"}, out_ctrl1, c);
        if (v) check({t, ".data1"}, out_data1, d);
        check({t, ".occ1"}, occ1, o);
        check({t, ".rdy1"}, in_ready1, r);
    endtask

    task automatic exp0(input string t, input logic v, input logic [7:0] c, input logic [127:0] d,
                        input logic [1:0] o, input logic r);
        check({t, ".valid0"}, out_valid0, v);
        check({t, ".ctrl0"}, out_ctrl0, c);
        if (v) check({t, ".data0"}, out_data0, d);
        check({t, ".occ0"}, occ0, o);
        check({t, ".rdy0"}, in_ready0, r);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 8'h00, 128'h0, 1'b1);
        #12;
        exp1("rst", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        check("rst.data1", out_data1, 128'h0);
        exp0("rst", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        tick();
        rst = 1'b0;
        // back-to-back stream, one entry per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 128'h100 + 128'(i), 1'b1);
            tick();
            exp1($sformatf("stream%0d", i), 1'b1, 8'(i), 128'h100 + 128'(i), 2'd1, 1'b1);
        end
        drive(1'b0, 8'h00, 128'h0, 1'b1);
        tick();
        exp1("drain", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        // skid stall: three cycles with out_ready low
        drive(1'b1, 8'h20, 128'h200, 1'b1);
        tick();
        exp1("st1.a", 1'b1, 8'h20, 128'h200, 2'd1, 1'b1);
        drive(1'b1, 8'h21, 128'h201, 1'b0);
        #1 check("st1.rdy_reg", in_ready1, 1'b1);
        tick();
        exp1("st1.b", 1'b1, 8'h20, 128'h200, 2'd2, 1'b0);
        drive(1'b1, 8'h22, 128'h202, 1'b0);
        tick();
        exp1("st1.c", 1'b1, 8'h20, 128'h200, 2'd2, 1'b0);
        tick();
        exp1("st1.d", 1'b1, 8'h20, 128'h200, 2'd2, 1'b0);
        drive(1'b1, 8'h22, 128'h202, 1'b1);
        tick();
        exp1("st1.e", 1'b1, 8'h21, 128'h201, 2'd1, 1'b1);
        tick();
        exp1("st1.f", 1'b1, 8'h22, 128'h202, 2'd1, 1'b1);
        drive(1'b0, 8'h00, 128'h0, 1'b1);
        tick();
        exp1("st1.g", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        // flush while full, then flush discarding an accepted input
        drive(1'b1, 8'h30, 128'h300, 1'b1);
        tick();
        drive(1'b1, 8'h31, 128'h301, 1'b0);
        tick();
        exp1("fl.two", 1'b1, 8'h30, 128'h300, 2'd2, 1'b0);
        flush = 1'b1;
        drive(1'b1, 8'h32, 128'h302, 1'b0);
        tick();
        flush = 1'b0;
        exp1("fl.a", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        check("fl.a.data1", out_data1, 128'h0);
        drive(1'b1, 8'h33, 128'h303, 1'b1);
        tick();
        exp1("fl.b", 1'b1, 8'h33, 128'h303, 2'd1, 1'b1);
        flush = 1'b1;
        drive(1'b1, 8'h34, 128'h304, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 128'h0, 1'b1);
        exp1("fl.c", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        check("fl.c.data1", out_data1, 128'h0);
        tick();
        exp1("fl.d", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        // bubble between entries with nonzero ctrl
        drive(1'b1, 8'hA5, 128'h3A5, 1'b1);
        tick();
        exp1("bub.a", 1'b1, 8'hA5, 128'h3A5, 2'd1, 1'b1);
        drive(1'b0, 8'hFF, 128'h3FF, 1'b1);
        tick();
        exp1("bub.b", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        drive(1'b1, 8'h5A, 128'h35A, 1'b1);
        tick();
        exp1("bub.c", 1'b1, 8'h5A, 128'h35A, 2'd1, 1'b1);
        // asynchronous reset between edges
        drive(1'b1, 8'h41, 128'h401, 1'b1);
        tick();
        exp1("ar.pre", 1'b1, 8'h41, 128'h401, 2'd1, 1'b1);
        #3 rst = 1'b1;
        #1 exp1("ar.async", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        check("ar.data1", out_data1, 128'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 8'h42, 128'h402, 1'b1);
        tick();
        exp1("ar.post", 1'b1, 8'h42, 128'h402, 2'd1, 1'b1);
        // single-register stage: in_ready follows out_ready combinationally
        drive(1'b0, 8'h00, 128'h0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp0("r0", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        drive(1'b1, 8'h50, 128'h500, 1'b1);
        tick();
        exp0("s0.a", 1'b1, 8'h50, 128'h500, 2'd1, 1'b1);
        drive(1'b1, 8'h51, 128'h501, 1'b0);
        #1 check("s0.rdy_low", in_ready0, 1'b0);
        tick();
        exp0("s0.b", 1'b1, 8'h50, 128'h500, 2'd1, 1'b0);
        tick();
        exp0("s0.c", 1'b1, 8'h50, 128'h500, 2'd1, 1'b0);
        tick();
        exp0("s0.d", 1'b1, 8'h50, 128'h500, 2'd1, 1'b0);
        out_ready = 1'b1;
        #1 check("s0.rdy_high", in_ready0, 1'b1);
        tick();
        exp0("s0.e", 1'b1, 8'h51, 128'h501, 2'd1, 1'b1);
        drive(1'b1, 8'h52, 128'h502, 1'b1);
        tick();
        exp0("s0.f", 1'b1, 8'h52, 128'h502, 2'd1, 1'b1);
        drive(1'b0, 8'h00, 128'h0, 1'b1);
        tick();
        exp0("s0.g", 1'b0, 8'h00, 128'h0, 2'd0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
